// File: rtl/channel_bank_pkg.sv
// rtl/channel_bank_pkg.sv - shared helpers and reset constants for channel_store_bank
package channel_bank_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Select/counter width: never narrower than one bit.
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    localparam logic RST_LEVEL = 1'b0;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, stability counter and rising-edge strobe
module btn_debounce
    import channel_bank_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise_stb
);

    localparam int              CNT_W    = sel_width(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= RST_LEVEL;
            sync2    <= RST_LEVEL;
            level    <= RST_LEVEL;
            cnt      <= '0;
            rise_stb <= 1'b0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            rise_stb <= 1'b0;
            // Any cycle where the levels agree restarts the stability window.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level    <= sync2;
                cnt      <= '0;
                rise_stb <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/channel_store_bank.sv
// rtl/channel_store_bank.sv - button-captured multi-channel store with scanned registered read port
module channel_store_bank
    import channel_bank_pkg::*;
#(
    parameter  int NUM_CH       = 4,
    parameter  int DATA_W       = 8,
    parameter  int DEBOUNCE_CYC = 1_000_000,
    parameter  int SCAN_CYC     = 50_000_000,
    localparam int SEL_W        = sel_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn,
    input  logic [DATA_W-1:0] din,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [SEL_W-1:0]  rd_sel,
    input  logic              scan_en,
    output logic [DATA_W-1:0] dout,
    output logic [SEL_W-1:0]  cur_ch,
    output logic [NUM_CH-1:0] valid,
    output logic              wr_stb
);

    localparam int               SCAN_W    = sel_width(SCAN_CYC);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYC - 1);
    localparam logic [SEL_W-1:0]  CH_LAST   = SEL_W'(NUM_CH - 1);

    logic [NUM_CH*DATA_W-1:0] mem;
    logic [SEL_W-1:0]         scan_idx;
    logic [SCAN_W-1:0]        scan_cnt;
    logic [SEL_W-1:0]         rd_idx;
    logic [DATA_W-1:0]        rd_data;
    logic                     btn_level;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .level   (btn_level),
        .rise_stb(wr_stb)
    );

    // Out-of-range indices match no channel and read as zero.
    always_comb begin
        rd_idx  = scan_en ? scan_idx : rd_sel;
        rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_idx == SEL_W'(i)) rd_data = mem[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem      <= '0;
            valid    <= '0;
            scan_idx <= '0;
            scan_cnt <= '0;
            dout     <= '0;
            cur_ch   <= '0;
        end else begin
            // The strobe only ever follows a rise, so the debounced level is high with it.
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_stb && btn_level && wr_sel == SEL_W'(i)) begin
                    mem[i*DATA_W +: DATA_W] <= din;
                    valid[i]                <= 1'b1;
                end
            end

            if (scan_en) begin
                if (scan_cnt == SCAN_LAST) begin
                    scan_cnt <= '0;
                    scan_idx <= (scan_idx == CH_LAST) ? '0 : scan_idx + SEL_W'(1);
                end else begin
                    scan_cnt <= scan_cnt + SCAN_W'(1);
                end
            end

            // Reads the pre-write array: a same-cycle write shows up one cycle later.
            dout   <= rd_data;
            cur_ch <= rd_idx;
        end
    end

endmodule

// File: tb/tb_channel_store_bank.sv
// tb/tb_channel_store_bank.sv - self-checking bench for channel_store_bank
module tb_channel_store_bank;

    localparam int DEB  = 4;
    localparam int SCAN = 3;

    logic       clk;
    logic       rst_n;
    logic       btn;
    logic [7:0] din;
    logic [1:0] wr_sel;
    logic [1:0] rd_sel;
    logic       scan_en;

    logic [7:0] a_dout;
    logic [1:0] a_cur;
    logic [3:0] a_valid;
    logic       a_wr_stb;
    logic [7:0] b_dout;
    logic [1:0] b_cur;
    logic [2:0] b_valid;
    logic       b_wr_stb;

    channel_store_bank #(
        .NUM_CH(4), .DATA_W(8), .DEBOUNCE_CYC(DEB), .SCAN_CYC(SCAN)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .btn(btn), .din(din), .wr_sel(wr_sel),
        .rd_sel(rd_sel), .scan_en(scan_en), .dout(a_dout), .cur_ch(a_cur),
        .valid(a_valid), .wr_stb(a_wr_stb)
    );

    channel_store_bank #(
        .NUM_CH(3), .DATA_W(8), .DEBOUNCE_CYC(DEB), .SCAN_CYC(SCAN)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .btn(btn), .din(din), .wr_sel(wr_sel),
        .rd_sel(rd_sel), .scan_en(scan_en), .dout(b_dout), .cur_ch(b_cur),
        .valid(b_valid), .wr_stb(b_wr_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit model_on = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: index 0 is the 4-channel bank, index 1 the 3-channel bank.
    int m_mem [2][4];
    int m_vld [2];
    int m_sidx[2];
    int m_scnt[2];
    int m_dout[2];
    int m_cur [2];
    int m_sync[2];
    int m_lvl, m_run, m_stb;
    int mi, msyn, mnstb;

    function automatic int nch(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 4; c++) m_mem[d][c] = 0;
                m_vld[d] = 0; m_sidx[d] = 0; m_scnt[d] = 0;
                m_dout[d] = 0; m_cur[d] = 0;
            end
            m_sync[0] = 0; m_sync[1] = 0;
            m_lvl = 0; m_run = 0; m_stb = 0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                mi = scan_en ? m_sidx[d] : int'(rd_sel);
                m_dout[d] = (mi < nch(d)) ? m_mem[d][mi] : 0;
                m_cur[d]  = mi;
                if (m_stb == 1 && int'(wr_sel) < nch(d)) begin
                    m_mem[d][wr_sel] = int'(din);
                    m_vld[d] = m_vld[d] | (1 << wr_sel);
                end
                if (scan_en) begin
                    m_scnt[d]++;
                    if (m_scnt[d] == SCAN) begin
                        m_scnt[d] = 0;
                        m_sidx[d] = (m_sidx[d] + 1) % nch(d);
                    end
                end
            end
            // Debounced level follows the synchronised level after DEB disagreeing cycles in a row.
            msyn  = m_sync[1];
            mnstb = 0;
            if (msyn != m_lvl) begin
                if (m_run == DEB - 1) begin
                    m_lvl = msyn; m_run = 0; mnstb = msyn;
                end else begin
                    m_run++;
                end
            end else begin
                m_run = 0;
            end
            m_stb     = mnstb;
            m_sync[1] = m_sync[0];
            m_sync[0] = int'(btn);
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("m_a_dout",  32'(a_dout),   32'(m_dout[0]));
            chk("m_a_cur",   32'(a_cur),    32'(m_cur[0]));
            chk("m_a_valid", 32'(a_valid),  32'(m_vld[0]));
            chk("m_a_stb",   32'(a_wr_stb), 32'(m_stb));
            chk("m_b_dout",  32'(b_dout),   32'(m_dout[1]));
            chk("m_b_cur",   32'(b_cur),    32'(m_cur[1]));
            chk("m_b_valid", 32'(b_valid),  32'(m_vld[1]));
            chk("m_b_stb",   32'(b_wr_stb), 32'(m_stb));
        end
    end

    typedef struct {
        logic       btn;
        logic [7:0] din;
        logic [1:0] wr_sel;
        logic [1:0] rd_sel;
        logic       exp_stb;
        logic [7:0] exp_dout;
        logic [3:0] exp_valid;
        logic [1:0] exp_cur;
    } vec_t;

    vec_t tbl[20];

    task automatic wr(input logic [1:0] ch, input logic [7:0] val);
        bit seen;
        seen   = 0;
        din    = val;
        wr_sel = ch;
        btn    = 1'b1;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick;
            if (a_wr_stb) seen = 1;
        end
        chk("wr_stb_seen", 32'(seen), 32'd1);
        btn = 1'b0;
        repeat (10) tick;
    endtask

    logic [7:0] scan_vals[4];
    int         stb_cnt;
    int         lat;
    bit         seen2;
    int         run;

    initial begin
        rst_n = 1'b0; btn = 1'b0; din = 8'h00; wr_sel = 2'd0; rd_sel = 2'd2; scan_en = 1'b0;

        // Row k is sampled at edge Ek after reset release with the button held.
        for (int k = 0; k < 20; k++) begin
            tbl[k].btn       = 1'b1;
            tbl[k].din       = 8'hA5;
            tbl[k].wr_sel    = 2'd2;
            tbl[k].rd_sel    = 2'd2;
            tbl[k].exp_stb   = (k == DEB + 1);
            tbl[k].exp_dout  = (k >= DEB + 3) ? 8'hA5 : 8'h00;
            tbl[k].exp_valid = (k >= DEB + 2) ? 4'b0100 : 4'b0000;
            tbl[k].exp_cur   = 2'd2;
        end

        tick;
        model_on = 1;
        tick;
        chk("rst_dout",  32'(a_dout),   32'd0);
        chk("rst_cur",   32'(a_cur),    32'd0);
        chk("rst_valid", 32'(a_valid),  32'd0);
        chk("rst_stb",   32'(a_wr_stb), 32'd0);

        stb_cnt = 0;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            btn = tbl[k].btn; din = tbl[k].din; wr_sel = tbl[k].wr_sel; rd_sel = tbl[k].rd_sel;
            tick;
            if (a_wr_stb) stb_cnt++;
            chk("tbl_stb",   32'(a_wr_stb), 32'(tbl[k].exp_stb));
            chk("tbl_dout",  32'(a_dout),   32'(tbl[k].exp_dout));
            chk("tbl_valid", 32'(a_valid),  32'(tbl[k].exp_valid));
            chk("tbl_cur",   32'(a_cur),    32'(tbl[k].exp_cur));
        end
        chk("one_strobe", 32'(stb_cnt), 32'd1);
        btn = 1'b0;
        repeat (10) tick;

        // Bounce: 3 high / 3 low never survives the stability window.
        stb_cnt = 0;
        for (int r = 0; r < 5; r++) begin
            btn = 1'b1;
            repeat (3) begin tick; if (a_wr_stb) stb_cnt++; end
            btn = 1'b0;
            repeat (3) begin tick; if (a_wr_stb) stb_cnt++; end
        end
        repeat (10) begin tick; if (a_wr_stb) stb_cnt++; end
        chk("bounce_stb",   32'(stb_cnt), 32'd0);
        chk("bounce_valid", 32'(a_valid), 32'b0100);
        chk("bounce_dout",  32'(a_dout),  32'hA5);

        // Scan wrap
        scan_vals[0] = 8'h11; scan_vals[1] = 8'h22; scan_vals[2] = 8'h33; scan_vals[3] = 8'h44;
        for (int c = 0; c < 4; c++) wr(2'(c), scan_vals[c]);
        chk("scan_valid", 32'(a_valid), 32'hF);
        scan_en = 1'b1;
        for (int j = 0; j < 15; j++) begin
            tick;
            chk("scan_cur",  32'(a_cur),  32'((j / SCAN) % 4));
            chk("scan_dout", 32'(a_dout), 32'(scan_vals[(j / SCAN) % 4]));
        end
        scan_en = 1'b0;

        // Same-channel write while reading it
        rd_sel = 2'd1;
        wr(2'd1, 8'h10);
        din = 8'h20; wr_sel = 2'd1; btn = 1'b1; seen2 = 0;
        for (int i = 0; i < 30 && !seen2; i++) begin
            tick;
            if (a_wr_stb) seen2 = 1;
        end
        chk("same_stb_seen", 32'(seen2), 32'd1);
        chk("same_old",      32'(a_dout), 32'h10);
        tick;
        chk("same_upd_edge", 32'(a_dout), 32'h10);
        tick;
        chk("same_new",      32'(a_dout), 32'h20);
        btn = 1'b0;
        repeat (10) tick;

        // Reset mid-debounce and mid-scan
        scan_en = 1'b1; btn = 1'b1; din = 8'h77; wr_sel = 2'd0;
        repeat (DEB) tick;
        rst_n = 1'b0;
        tick;
        chk("mid_rst_dout",   32'(a_dout),   32'd0);
        chk("mid_rst_cur",    32'(a_cur),    32'd0);
        chk("mid_rst_valid",  32'(a_valid),  32'd0);
        chk("mid_rst_stb",    32'(a_wr_stb), 32'd0);
        chk("mid_rst_bvalid", 32'(b_valid),  32'd0);
        rst_n = 1'b1;
        lat = 0; seen2 = 0;
        for (int i = 0; i < 20 && !seen2; i++) begin
            tick;
            lat++;
            if (a_wr_stb) seen2 = 1;
        end
        chk("mid_rst_latency", 32'(lat), 32'(DEB + 2));
        btn = 1'b0; scan_en = 1'b0;
        repeat (10) tick;

        // Out-of-range write/read on the 3-channel bank
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        rd_sel = 2'd0;
        wr(2'd3, 8'h5A);
        chk("nch3_valid", 32'(b_valid), 32'd0);
        rd_sel = 2'd3;
        tick;
        chk("nch3_dout",  32'(b_dout),  32'd0);
        chk("nch3_cur",   32'(b_cur),   32'd3);
        chk("nch4_dout3", 32'(a_dout),  32'h5A);
        chk("nch4_valid", 32'(a_valid), 32'b1000);

        // Randomised phase against the model
        run = 0;
        for (int c = 0; c < 600; c++) begin
            if (run == 0) begin
                btn = ~btn;
                run = $urandom_range(1, 9);
            end
            run--;
            din    = 8'($urandom);
            wr_sel = 2'($urandom);
            rd_sel = 2'($urandom);
            if ($urandom_range(0, 19) == 0) scan_en = ~scan_en;
            rst_n  = ($urandom_range(0, 149) != 0);
            tick;
        end
        rst_n = 1'b1;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
